// File: rtl/aes_inv_mixcolumns_serial.sv
// Column-serial AES InvMixColumns engine.
// Accepts a 128-bit state, transforms one 32-bit column per clock over four
// clocks (or copies it unchanged in bypass mode), then presents the result
// until downstream takes it. A new state may be accepted on the same edge
// that the previous result is delivered.
module aes_inv_mixcolumns_serial (
   input  logic         clk,
   input  logic         rst,
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [127:0] state_in,
   input  logic         in_bypass,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [127:0] state_out,
   output logic         busy
);

   localparam int unsigned BYTE_W  = 8;
   localparam int unsigned COL_W   = 32;
   localparam int unsigned STATE_W = 128;
   localparam int unsigned CNT_W   = 2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } fsm_t;

   fsm_t               state;
   logic [CNT_W-1:0]   col_cnt;
   logic [STATE_W-1:0] in_buf;
   logic               bypass_q;
   logic [COL_W-1:0]   col_in;
   logic [COL_W-1:0]   col_res;

   // Multiply by x (0x02) modulo x^8 + x^4 + x^3 + x + 1.
   function automatic logic [BYTE_W-1:0] xtime(input logic [BYTE_W-1:0] b);
      xtime = {b[BYTE_W-2:0], 1'b0} ^ (b[BYTE_W-1] ? 8'h1B : 8'h00);
   endfunction

   // 0x09 = x8 ^ x
   function automatic logic [BYTE_W-1:0] mul09(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] x2, x4, x8;
      x2    = xtime(b);
      x4    = xtime(x2);
      x8    = xtime(x4);
      mul09 = x8 ^ b;
   endfunction

   // 0x0B = x8 ^ x2 ^ x
   function automatic logic [BYTE_W-1:0] mul0b(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] x2, x4, x8;
      x2    = xtime(b);
      x4    = xtime(x2);
      x8    = xtime(x4);
      mul0b = x8 ^ x2 ^ b;
   endfunction

   // 0x0D = x8 ^ x4 ^ x
   function automatic logic [BYTE_W-1:0] mul0d(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] x2, x4, x8;
      x2    = xtime(b);
      x4    = xtime(x2);
      x8    = xtime(x4);
      mul0d = x8 ^ x4 ^ b;
   endfunction

   // 0x0E = x8 ^ x4 ^ x2
   function automatic logic [BYTE_W-1:0] mul0e(input logic [BYTE_W-1:0] b);
      logic [BYTE_W-1:0] x2, x4, x8;
      x2    = xtime(b);
      x4    = xtime(x2);
      x8    = xtime(x4);
      mul0e = x8 ^ x4 ^ x2;
   endfunction

   // One column through the inverse matrix; row 0 is the MSB byte.
   function automatic logic [COL_W-1:0] inv_mix_col(input logic [COL_W-1:0] c);
      logic [BYTE_W-1:0] a0, a1, a2, a3;
      logic [BYTE_W-1:0] r0, r1, r2, r3;
      a0 = c[31:24];
      a1 = c[23:16];
      a2 = c[15:8];
      a3 = c[7:0];
      r0 = mul0e(a0) ^ mul0b(a1) ^ mul0d(a2) ^ mul09(a3);
      r1 = mul0e(a1) ^ mul0b(a2) ^ mul0d(a3) ^ mul09(a0);
      r2 = mul0e(a2) ^ mul0b(a3) ^ mul0d(a0) ^ mul09(a1);
      r3 = mul0e(a3) ^ mul0b(a0) ^ mul0d(a1) ^ mul09(a2);
      inv_mix_col = {r0, r1, r2, r3};
   endfunction

   // Ready depends on state and out_ready only, never on in_valid.
   assign in_ready = !rst && ((state == IDLE) || ((state == DONE) && out_ready));

   // Select the column addressed by col_cnt from the input buffer.
   always_comb begin
      col_in = '0;
      case (col_cnt)
         2'd0:    col_in = in_buf[127:96];
         2'd1:    col_in = in_buf[95:64];
         2'd2:    col_in = in_buf[63:32];
         default: col_in = in_buf[31:0];
      endcase
   end

   // Transform or pass through the selected column.
   always_comb begin
      col_res = col_in;
      if (!bypass_q) begin
         col_res = inv_mix_col(col_in);
      end
   end

   // Control FSM, input buffer and registered outputs.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         col_cnt   <= '0;
         in_buf    <= '0;
         bypass_q  <= 1'b0;
         state_out <= '0;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  in_buf   <= state_in;
                  bypass_q <= in_bypass;
                  col_cnt  <= '0;
                  busy     <= 1'b1;
                  state    <= RUN;
               end
            end
            RUN: begin
               case (col_cnt)
                  2'd0:    state_out[127:96] <= col_res;
                  2'd1:    state_out[95:64]  <= col_res;
                  2'd2:    state_out[63:32]  <= col_res;
                  default: state_out[31:0]   <= col_res;
               endcase
               col_cnt <= col_cnt + CNT_W'(1);
               if (col_cnt == CNT_W'(3)) begin
                  out_valid <= 1'b1;
                  state     <= DONE;
               end
            end
            DONE: begin
               if (out_ready) begin
                  out_valid <= 1'b0;
                  if (in_valid) begin
                     // Deliver and accept on the same edge.
                     in_buf   <= state_in;
                     bypass_q <= in_bypass;
                     col_cnt  <= '0;
                     state    <= RUN;
                  end else begin
                     busy  <= 1'b0;
                     state <= IDLE;
                  end
               end
            end
            default: begin
               out_valid <= 1'b0;
               busy      <= 1'b0;
               state     <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_aes_inv_mixcolumns_serial.sv
// Bench for aes_inv_mixcolumns_serial: directed vector table, protocol corner
// sequences, and a randomized stream checked against a GF(2^8) matrix model.
module tb_aes_inv_mixcolumns_serial;

   logic         clk;
   logic         rst;
   logic         in_valid;
   logic         in_ready;
   logic [127:0] state_in;
   logic         in_bypass;
   logic         out_valid;
   logic         out_ready;
   logic [127:0] state_out;
   logic         busy;

   int n_checks;
   int n_fail;

   aes_inv_mixcolumns_serial dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .state_in  (state_in),
      .in_bypass (in_bypass),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .state_out (state_out),
      .busy      (busy)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic [127:0] din;
      logic         byp;
      logic [127:0] exp;
      string        name;
   } vec_t;

   localparam logic [127:0] KAT_IN  = 128'h8e4da1bc_9fdc589d_01010101_4d7ebdf8;
   localparam logic [127:0] KAT_OUT = 128'hdb135345_f20a225c_01010101_2d26314c;
   localparam logic [127:0] B_IN    = 128'h01010101_c6c6c6c6_d5d5d7d6_01010101;
   localparam logic [127:0] B_OUT   = 128'h01010101_c6c6c6c6_d4d4d4d5_01010101;

   // Generic shift-and-add multiply in GF(2^8) with polynomial 0x11B.
   function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, aa, bb;
      p  = 8'h00;
      aa = a;
      bb = b;
      for (int i = 0; i < 8; i++) begin
         if (bb[0]) p = p ^ aa;
         aa = aa[7] ? ((aa << 1) ^ 8'h1B) : (aa << 1);
         bb = bb >> 1;
      end
      return p;
   endfunction

   // Circulant matrix product on every column; coef holds the first matrix row.
   function automatic logic [127:0] mix_generic(input logic [127:0] s, input logic [31:0] coef);
      logic [127:0] r;
      logic [7:0]   a [4];
      logic [7:0]   m [4];
      logic [7:0]   acc;
      r = '0;
      for (int k = 0; k < 4; k++) m[k] = coef[31-8*k -: 8];
      for (int c = 0; c < 4; c++) begin
         for (int k = 0; k < 4; k++) a[k] = s[127-32*c-8*k -: 8];
         for (int row = 0; row < 4; row++) begin
            acc = 8'h00;
            for (int k = 0; k < 4; k++) acc = acc ^ gf_mul(m[k], a[(row+k)%4]);
            r[127-32*c-8*row -: 8] = acc;
         end
      end
      return r;
   endfunction

   function automatic logic [127:0] ref_inv(input logic [127:0] s, input logic byp);
      return byp ? s : mix_generic(s, 32'h0e0b0d09);
   endfunction

   function automatic logic [127:0] ref_fwd(input logic [127:0] s);
      return mix_generic(s, 32'h02030101);
   endfunction

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // One isolated transaction with out_ready high: latency, data, single-cycle valid.
   task automatic run_vector(input logic [127:0] din, input logic byp,
                             input logic [127:0] exp, input string name);
      int lat;
      out_ready = 1'b1;
      in_valid  = 1'b1;
      state_in  = din;
      in_bypass = byp;
      #1;
      check({name, "_in_ready"}, 128'(in_ready), 128'(1));
      tick();
      in_valid  = 1'b0;
      state_in  = {$urandom, $urandom, $urandom, $urandom};
      in_bypass = ~byp;
      lat = 0;
      while (!out_valid && lat < 20) begin
         tick();
         lat++;
      end
      check({name, "_latency"}, 128'(lat), 128'(4));
      check({name, "_data"}, state_out, exp);
      tick();
      check({name, "_valid_pulse"}, 128'(out_valid), 128'(0));
      check({name, "_idle"}, 128'({busy, in_ready}), 128'(2'b01));
   endtask

   initial begin
      vec_t         vecs[5];
      logic [127:0] held;
      logic [127:0] q_exp[$];
      logic [127:0] q_org[$];
      logic         q_byp[$];
      logic [127:0] cur_data, got_exp, got_org;
      logic         cur_byp, have_cur, got_byp;
      logic         s_in_ready, s_out_valid, seen_valid;
      logic [127:0] s_state_out;
      int           sent, recvd, cyc;

      n_checks = 0;
      n_fail   = 0;

      vecs[0] = '{din: KAT_IN,       byp: 1'b0, exp: KAT_OUT,      name: "kat"};
      vecs[1] = '{din: KAT_IN,       byp: 1'b1, exp: KAT_IN,       name: "kat_bypass"};
      vecs[2] = '{din: B_IN,         byp: 1'b0, exp: B_OUT,        name: "vec_b"};
      vecs[3] = '{din: B_IN,         byp: 1'b1, exp: B_IN,         name: "vec_b_bypass"};
      vecs[4] = '{din: {128{1'b1}},  byp: 1'b0, exp: {128{1'b1}},  name: "all_ones"};

      // Reset state.
      rst       = 1'b1;
      in_valid  = 1'b0;
      state_in  = '0;
      in_bypass = 1'b0;
      out_ready = 1'b1;
      tick();
      tick();
      check("rst_in_ready", 128'(in_ready), 128'(0));
      check("rst_out_valid_busy", 128'({out_valid, busy}), 128'(0));
      check("rst_state_out", state_out, 128'h0);
      rst = 1'b0;
      #1;
      check("post_rst_in_ready", 128'(in_ready), 128'(1));

      // Directed vector table.
      for (int i = 0; i < 5; i++) begin
         run_vector(vecs[i].din, vecs[i].byp, vecs[i].exp, vecs[i].name);
      end

      // Backpressure: result must hold for 10 stalled cycles.
      out_ready = 1'b0;
      in_valid  = 1'b1;
      state_in  = KAT_IN;
      in_bypass = 1'b0;
      tick();
      in_valid = 1'b0;
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("bp_latency", 128'(cyc), 128'(4));
      held = state_out;
      check("bp_data", held, KAT_OUT);
      for (int i = 0; i < 10; i++) begin
         in_valid = (i == 3);
         state_in = B_IN;
         #1;
         check("bp_in_ready", 128'(in_ready), 128'(0));
         tick();
         check("bp_out_valid", 128'(out_valid), 128'(1));
         check("bp_stable", state_out, held);
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      tick();
      check("bp_release", 128'({out_valid, busy, in_ready}), 128'(3'b001));
      tick();
      check("bp_no_second", 128'({out_valid, busy}), 128'(0));

      // Back-to-back: B accepted on the edge that delivers A.
      out_ready = 1'b1;
      in_valid  = 1'b1;
      state_in  = KAT_IN;
      in_bypass = 1'b0;
      tick();
      state_in = B_IN;
      for (int i = 0; i < 4; i++) tick();
      check("b2b_a_valid", 128'(out_valid), 128'(1));
      check("b2b_a_data", state_out, KAT_OUT);
      check("b2b_ready_in_done", 128'(in_ready), 128'(1));
      tick();
      in_valid = 1'b0;
      check("b2b_b_running", 128'({out_valid, busy}), 128'(2'b01));
      cyc = 0;
      while (!out_valid && cyc < 20) begin
         tick();
         cyc++;
      end
      check("b2b_spacing", 128'(cyc + 1), 128'(5));
      check("b2b_b_data", state_out, B_OUT);
      tick();
      check("b2b_end", 128'({out_valid, busy}), 128'(0));

      // Reset during the second RUN cycle abandons the block.
      in_valid  = 1'b1;
      state_in  = KAT_IN;
      in_bypass = 1'b0;
      tick();
      in_valid = 1'b0;
      tick();
      rst = 1'b1;
      tick();
      rst = 1'b0;
      #1;
      check("midrun_rst_outputs", 128'({out_valid, busy, in_ready}), 128'(3'b001));
      check("midrun_rst_state_out", state_out, 128'h0);
      seen_valid = 1'b0;
      for (int i = 0; i < 6; i++) begin
         tick();
         seen_valid = seen_valid | out_valid;
      end
      check("midrun_no_valid", 128'(seen_valid), 128'(0));
      run_vector(KAT_IN, 1'b0, KAT_OUT, "post_rst_kat");

      // Random stream with random stalls and idle gaps.
      sent     = 0;
      recvd    = 0;
      cyc      = 0;
      have_cur = 1'b0;
      cur_data = '0;
      cur_byp  = 1'b0;
      while (recvd < 1000 && cyc < 30000) begin
         out_ready = ($urandom_range(3, 0) != 0);
         if (!have_cur && sent < 1000 && ($urandom_range(4, 0) != 0)) begin
            cur_data = {$urandom, $urandom, $urandom, $urandom};
            cur_byp  = ($urandom_range(7, 0) == 0);
            have_cur = 1'b1;
         end
         in_valid  = have_cur;
         state_in  = have_cur ? cur_data : {$urandom, $urandom, $urandom, $urandom};
         in_bypass = have_cur ? cur_byp : 1'($urandom);
         #1;
         s_in_ready  = in_ready;
         s_out_valid = out_valid;
         s_state_out = state_out;
         if (s_out_valid && out_ready) begin
            if (q_exp.size() == 0) begin
               check("rnd_unexpected_output", s_state_out, 128'hx);
            end else begin
               got_exp = q_exp.pop_front();
               got_org = q_org.pop_front();
               got_byp = q_byp.pop_front();
               check("rnd_data", s_state_out, got_exp);
               if (!got_byp) check("rnd_fwd_roundtrip", ref_fwd(s_state_out), got_org);
            end
            recvd++;
         end
         if (in_valid && s_in_ready) begin
            q_exp.push_back(ref_inv(cur_data, cur_byp));
            q_org.push_back(cur_data);
            q_byp.push_back(cur_byp);
            have_cur = 1'b0;
            sent++;
         end
         @(posedge clk);
         #1;
         cyc++;
      end
      check("rnd_all_received", 128'(recvd), 128'(1000));

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
